melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
- Plays a stored melody by driving the 4-bit note select `S` of the tone generator.
- Steps through a note ROM. Each ROM entry is one byte: a note code plus a duration in ticks.
- Each note is held for its duration, then a short silent articulation gap follows.
- Supports start, stop, looping and end-of-song detection. Sits between user controls and the tone generator.

Parameters:
- TICK_DIV, 6250000, clocks per duration tick (125 ms at 50 MHz).
- ADDR_W, 6, ROM address width (64 entries).
- GAP_TICKS, 1, silent ticks inserted after every note (0 = no gap).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- play  in  1  start playback from address 0 (level-sampled, acted on only in IDLE)
- stop  in  1  abort playback (priority over play)
- loop  in  1  when 1, the terminator entry restarts the song instead of ending it
- rom_addr  out  ADDR_W  note ROM read address
- rom_data  in  8  ROM data, registered, valid 1 cycle after rom_addr; [7:4] note code, [3:0] length in ticks
- S  out  4  note select to tone generator; 0 = silence
- busy  out  1  high while a song is in progress
- note_strobe  out  1  1-cycle pulse on the first cycle of each note
- song_done  out  1  1-cycle pulse at normal end of song

Behaviour:
- Reset (rst=1 at clk edge; overrides every other input, in any state):
  - state=IDLE; S=0, rom_addr=0, busy=0, note_strobe=0, song_done=0.
  - tick counter and duration counter cleared.
- States: IDLE, FETCH, LOAD, NOTE, GAP, DONE.
- IDLE: S=0, busy=0.
  - play=1 and stop=0 → rom_addr<=0, go to FETCH.
  - play=1 and stop=1 → stay in IDLE.
- FETCH: busy=1, S=0. Waits one cycle for ROM latency, then LOAD.
- LOAD: busy=1, S=0. Samples rom_data.
  - length==0 (terminator) and loop=1 → rom_addr<=0, go to FETCH.
  - length==0 and loop=0 → DONE.
  - Otherwise → NOTE, with:
    - S<=code if code<=12, else S<=0 (codes 13–15 are rests);
    - dur_cnt<=length, tick_cnt<=0;
    - note_strobe=1 on the first NOTE cycle.
- NOTE: S holds for exactly length*TICK_DIV cycles.
  - tick_cnt counts 0..TICK_DIV-1, then wraps; each wrap decrements dur_cnt.
  - On the final cycle (dur_cnt==1 and tick_cnt==TICK_DIV-1):
    - GAP_TICKS>0 → GAP;
    - GAP_TICKS==0 → advance.
- GAP: S=0 for exactly GAP_TICKS*TICK_DIV cycles, then advance.
- Advance: rom_addr<=rom_addr+1, go to FETCH.
  - Address wraps modulo 2^ADDR_W. A ROM with no terminator plays forever.
- Note-to-note silence is therefore GAP_TICKS*TICK_DIV + 2 cycles (FETCH + LOAD).
- DONE: one cycle; song_done=1, busy=0, S=0; then IDLE.
- stop=1 in FETCH/LOAD/NOTE/GAP/DONE:
  - next state is IDLE; S=0 and busy=0 from the next cycle.
  - song_done is not pulsed; rom_addr<=0.
- play while busy is ignored: no restart, no effect on counters.
- A change of loop takes effect at the next terminator only.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Common bench settings: TICK_DIV=4, GAP_TICKS=1, ROM = {0x32, 0xE1, 0x11, 0x00}.
- Reset: rst=1 for 2 cycles with play=1 → S=0, busy=0, rom_addr=0, no strobes, stays in IDLE.
- Single play:
  - play pulse at cycle 0 → busy=1 from cycle 1.
  - S=3 on cycles 3–10 with note_strobe at cycle 3, then S=0 for 6 cycles.
  - S=0 for 4 cycles (code 14 is a rest) with note_strobe still pulsing.
  - S=1 for 4 cycles, then S=0 for 6 cycles.
  - song_done pulse, busy=0 on the following cycle.
- Loop: loop=1, same ROM → after the terminator, rom_addr returns to 0, S=3 reappears, and song_done never pulses.
- Stop mid-note: stop=1 on the 3rd cycle of S=3 → next cycle S=0, busy=0, state IDLE, no song_done. A play pulse issued earlier, during the note, had no effect.
- Simultaneous inputs: play=1 and stop=1 in IDLE → remains IDLE. rst=1 asserted during GAP → all outputs at reset values the next cycle.
- Address wrap: ADDR_W=2 with ROM {0x51,0x61,0x71,0x81}, no terminator → S sequence 5,6,7,8,5,… continues with rom_addr wrapping 3→0.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer
// Plays a stored melody by stepping through a note ROM and driving the
// 4-bit note select S of a tone generator. Each ROM byte holds a note code
// in [7:4] and a duration in ticks in [3:0]; a zero duration is the
// end-of-song terminator. After every note a silent gap of GAP_TICKS ticks
// is inserted.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   play         start playback from address 0 (acted on only in IDLE)
//   stop         abort playback, priority over play
//   loop         terminator restarts the song instead of ending it
//   rom_addr     note ROM read address
//   rom_data     registered ROM data, valid one cycle after rom_addr
//   S            note select to tone generator, 0 = silence
//   busy         high while a song is in progress
//   note_strobe  1-cycle pulse on the first cycle of each note
//   song_done    1-cycle pulse at normal end of song
//   dbg_state    current FSM state, for observation only
//
// All outputs are registered: the next-state logic computes the value each
// output will hold in the next state, and it is captured with the state.
module melody_sequencer #(
    parameter int TICK_DIV  = 6250000,
    parameter int ADDR_W    = 6,
    parameter int GAP_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        S,
    output logic              busy,
    output logic              note_strobe,
    output logic              song_done,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        NOTE  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // The duration counter also times the gap, so it must fit GAP_TICKS.
    localparam int DUR_W  = ($clog2(GAP_TICKS + 1) > 4) ? $clog2(GAP_TICKS + 1) : 4;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0]  GAP_LEN   = DUR_W'(GAP_TICKS);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [3:0]          s_d;
    logic                busy_d, strobe_d, done_d;
    logic [TICK_W-1:0]   tick_cnt, tick_d;
    logic [DUR_W-1:0]    dur_cnt, dur_d;
    logic                tick_end, last_cycle;
    logic [3:0]          rom_code, rom_len;

    assign rom_code   = rom_data[7:4];
    assign rom_len    = rom_data[3:0];
    assign tick_end   = (tick_cnt == TICK_LAST);
    // Final cycle of the current note or gap period.
    assign last_cycle = tick_end && (dur_cnt == DUR_W'(1));
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rom_addr    <= '0;
            S           <= 4'd0;
            busy        <= 1'b0;
            note_strobe <= 1'b0;
            song_done   <= 1'b0;
            tick_cnt    <= '0;
            dur_cnt     <= '0;
        end else begin
            state       <= state_d;
            rom_addr    <= addr_d;
            S           <= s_d;
            busy        <= busy_d;
            note_strobe <= strobe_d;
            song_done   <= done_d;
            tick_cnt    <= tick_d;
            dur_cnt     <= dur_d;
        end
    end

    always_comb begin
        state_d  = state;
        addr_d   = rom_addr;
        s_d      = S;
        busy_d   = busy;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        tick_d   = tick_cnt;
        dur_d    = dur_cnt;

        case (state)
            IDLE: begin
                s_d    = 4'd0;
                busy_d = 1'b0;
                if (play && !stop) begin
                    state_d = FETCH;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            FETCH: begin
                // rom_data for the current address arrives next cycle.
                state_d = LOAD;
            end
            LOAD: begin
                if (rom_len == 4'd0) begin
                    if (loop) begin
                        state_d = FETCH;
                        addr_d  = '0;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d  = NOTE;
                    // Codes 13..15 are rests: timed like notes but silent.
                    s_d      = (rom_code <= 4'd12) ? rom_code : 4'd0;
                    strobe_d = 1'b1;
                    dur_d    = DUR_W'(rom_len);
                    tick_d   = '0;
                end
            end
            NOTE: begin
                tick_d = tick_end ? '0 : tick_cnt + 1'b1;
                if (tick_end) begin
                    dur_d = dur_cnt - 1'b1;
                end
                if (last_cycle) begin
                    s_d = 4'd0;
                    if (GAP_TICKS > 0) begin
                        state_d = GAP;
                        dur_d   = GAP_LEN;
                        tick_d  = '0;
                    end else begin
                        state_d = FETCH;
                        addr_d  = rom_addr + 1'b1;
                    end
                end
            end
            GAP: begin
                tick_d = tick_end ? '0 : tick_cnt + 1'b1;
                if (tick_end) begin
                    dur_d = dur_cnt - 1'b1;
                end
                if (last_cycle) begin
                    state_d = FETCH;
                    addr_d  = rom_addr + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                s_d     = 4'd0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                s_d     = 4'd0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides everything except reset; no song_done on abort.
        if (stop && state != IDLE) begin
            state_d  = IDLE;
            addr_d   = '0;
            s_d      = 4'd0;
            busy_d   = 1'b0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer
// Self-checking bench for melody_sequencer. Expected per-cycle output
// vectors are generated from the ROM contents and the song timing
// (2 fetch cycles, length*TD note cycles, GAP*TD gap cycles per entry),
// pushed to exp_q when a song is started, and popped one per cycle.
module tb_melody_sequencer;

    localparam int TD   = 4;
    localparam int GAPT = 1;

    logic       clk;
    logic       rst;
    logic       play, stop, loop;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] s;
    logic       busy, note_strobe, song_done;
    logic [2:0] dbg_state;

    logic       play2, stop2;
    logic [1:0] rom_addr2;
    logic [7:0] rom_data2;
    logic [3:0] s2;
    logic       busy2, note_strobe2, song_done2;
    logic [2:0] dbg_state2;

    logic [7:0] rom  [4];
    logic [7:0] rom2 [4];

    // Expected vector: {addr_care, addr[5:0], S[3:0], busy, note_strobe, song_done}
    logic [13:0] exp_q[$];

    int  n_checks;
    int  n_fail;
    int  cyc;
    bit  sel;
    int  n;

    melody_sequencer #(.TICK_DIV(TD), .ADDR_W(6), .GAP_TICKS(GAPT)) dut (
        .clk(clk), .rst(rst), .play(play), .stop(stop), .loop(loop),
        .rom_addr(rom_addr), .rom_data(rom_data), .S(s), .busy(busy),
        .note_strobe(note_strobe), .song_done(song_done), .dbg_state(dbg_state)
    );

    melody_sequencer #(.TICK_DIV(TD), .ADDR_W(2), .GAP_TICKS(GAPT)) dut_wrap (
        .clk(clk), .rst(rst), .play(play2), .stop(stop2), .loop(1'b0),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .S(s2), .busy(busy2),
        .note_strobe(note_strobe2), .song_done(song_done2), .dbg_state(dbg_state2)
    );

    // ---------------- clock / ROM models ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rom_data  <= rom[rom_addr[1:0]];
        rom_data2 <= rom2[rom_addr2];
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] vec(input bit care, input int addr, input int sv,
                                        input bit b, input bit st, input bit d);
        return {care, 6'(addr), 4'(sv), b, st, d};
    endfunction

    task automatic push_idle(input bit care);
        exp_q.push_back(vec(care, 0, 0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic push_fetch_load(input int addr);
        exp_q.push_back(vec(1'b1, addr, 0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(vec(1'b1, addr, 0, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic push_entry(input logic [7:0] e, input int addr);
        int code, len, sv;
        code = int'(e[7:4]);
        len  = int'(e[3:0]);
        sv   = (code <= 12) ? code : 0;
        push_fetch_load(addr);
        for (int i = 0; i < len * TD; i++)
            exp_q.push_back(vec(1'b1, addr, sv, 1'b1, i == 0, 1'b0));
        for (int i = 0; i < GAPT * TD; i++)
            exp_q.push_back(vec(1'b1, addr, 0, 1'b1, 1'b0, 1'b0));
    endtask

    // Terminator without loop: fetch/load, one DONE cycle, then idle.
    task automatic push_term(input int addr);
        push_fetch_load(addr);
        exp_q.push_back(vec(1'b0, 0, 0, 1'b0, 1'b0, 1'b1));
        push_idle(1'b0);
        push_idle(1'b0);
    endtask

    task automatic tick_check(input string name);
        logic [13:0] e, o;
        @(negedge clk);
        cyc++;
        e = exp_q.pop_front();
        if (sel)
            o = {1'b1, 4'b0, rom_addr2, s2, busy2, note_strobe2, song_done2};
        else
            o = {1'b1, rom_addr, s, busy, note_strobe, song_done};
        if (!e[13]) begin
            o[13:7] = '0;
            e[13:7] = '0;
        end
        check($sformatf("%s@%0d", name, cyc), 32'(o), 32'(e));
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) tick_check(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rom[0] = 8'h32; rom[1] = 8'hE1; rom[2] = 8'h11; rom[3] = 8'h00;
        rom2[0] = 8'h51; rom2[1] = 8'h61; rom2[2] = 8'h71; rom2[3] = 8'h81;
        n_checks = 0; n_fail = 0; cyc = 0; sel = 1'b0;
        rst = 1'b1; play = 1'b1; stop = 1'b0; loop = 1'b0;
        play2 = 1'b0; stop2 = 1'b0;

        // Reset held two cycles with play high: stays idle.
        @(negedge clk);
        push_idle(1'b1);
        tick_check("reset");
        sel = 1'b1;
        push_idle(1'b1);
        tick_check("reset_wrap");
        sel = 1'b0;
        rst = 1'b0; play = 1'b0;
        push_idle(1'b1); push_idle(1'b1);
        drain("reset_idle");

        // Single play to the terminator.
        @(negedge clk); play = 1'b1;
        for (int i = 0; i < 3; i++) push_entry(rom[i], i);
        push_term(3);
        tick_check("play"); play = 1'b0;
        drain("play");

        // Loop: terminator restarts from address 0, no song_done.
        loop = 1'b1;
        @(negedge clk); play = 1'b1;
        for (int i = 0; i < 3; i++) push_entry(rom[i], i);
        push_fetch_load(3);
        push_entry(rom[0], 0);
        tick_check("loop"); play = 1'b0;
        drain("loop");
        stop = 1'b1;
        push_idle(1'b1);
        tick_check("loop_stop");
        stop = 1'b0; loop = 1'b0;

        // Stop on 3rd cycle of first note; earlier play during note ignored.
        @(negedge clk); play = 1'b1;
        push_entry(rom[0], 0);
        while (exp_q.size() > 5) void'(exp_q.pop_back());
        for (int i = 0; i < 4; i++) push_idle(1'b1);
        n = 0;
        while (exp_q.size() > 0) begin
            tick_check("stop_note");
            n++;
            play = (n == 4);
            stop = (n == 5);
        end
        play = 1'b0; stop = 1'b0;

        // play and stop together in IDLE: remain idle.
        @(negedge clk); play = 1'b1; stop = 1'b1;
        for (int i = 0; i < 3; i++) push_idle(1'b1);
        tick_check("play_stop"); play = 1'b0; stop = 1'b0;
        drain("play_stop");

        // Reset asserted during the gap after the second entry (rom_addr=1).
        @(negedge clk); play = 1'b1;
        push_entry(rom[0], 0);
        push_entry(rom[1], 1);
        while (exp_q.size() > 22) void'(exp_q.pop_back());
        for (int i = 0; i < 3; i++) push_idle(1'b1);
        n = 0;
        while (exp_q.size() > 0) begin
            tick_check("rst_gap");
            n++;
            play = 1'b0;
            rst  = (n == 22);
        end
        rst = 1'b0;

        // Address wrap with a 2-bit ROM and no terminator.
        sel = 1'b1;
        @(negedge clk); play2 = 1'b1;
        for (int i = 0; i < 6; i++) push_entry(rom2[i % 4], i % 4);
        tick_check("wrap"); play2 = 1'b0;
        drain("wrap");
        stop2 = 1'b1;
        push_idle(1'b1);
        tick_check("wrap_stop");
        stop2 = 1'b0;
        sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
